// File: rtl/bp_be_stride_pf_ctrl.sv
// Stride prefetch controller: forwards committed loads to the RPT, and on a confirmed
// stride issues up to degree_p same-page prefetches through a valid/ready port.

typedef enum logic [1:0] {e_bp_default_cfg, e_bp_sv48_cfg} bp_params_e;

module bp_be_stride_pf_ctrl
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   , parameter int stride_width_p = 8
   , parameter int degree_p = 2
   , parameter int rpt_latency_p = 2
   , localparam int vaddr_width_p = (bp_params_p == e_bp_sv48_cfg) ? 48 : 39
   )
   (input  logic                             clk_i
   , input  logic                            reset_i
   , input  logic                            ld_v_i
   , input  logic [vaddr_width_p-1:0]        ld_pc_i
   , input  logic [vaddr_width_p-1:0]        ld_eff_addr_i
   , output logic                            rpt_w_v_o
   , output logic [vaddr_width_p-1:0]        rpt_pc_o
   , output logic [vaddr_width_p-1:0]        rpt_eff_addr_o
   , input  logic                            rpt_init_done_i
   , input  logic                            stride_v_i
   , input  logic [stride_width_p-1:0]       stride_i
   , input  logic                            start_discovery_i
   , input  logic                            confirm_discovery_i
   , input  logic                            demand_v_i
   , output logic                            pf_v_o
   , output logic [vaddr_width_p-1:0]        pf_addr_o
   , input  logic                            pf_ready_i
   , output logic                            busy_o
   , output logic [7:0]                      drop_cnt_o
   );

   typedef enum logic [1:0] {e_init, e_idle, e_issue} state_e;

   function automatic logic signed [vaddr_width_p-1:0] sext
     (input logic [stride_width_p-1:0] s);
      return {{(vaddr_width_p-stride_width_p){s[stride_width_p-1]}}, s};
   endfunction

   function automatic logic same_page
     (input logic [vaddr_width_p-1:0] a, input logic [vaddr_width_p-1:0] b);
      return a[vaddr_width_p-1:12] == b[vaddr_width_p-1:12];
   endfunction

   state_e                          state_q, state_d;
   logic                            armed_q, armed_d;
   logic                            hold_q, hold_d;
   logic [2:0]                      remaining_q, remaining_d;
   logic [vaddr_width_p-1:0]        addr_q, addr_d;
   logic [vaddr_width_p-1:0]        base_q, base_d;
   logic signed [vaddr_width_p-1:0] stride_q, stride_d;
   logic [7:0]                      drop_cnt_q, drop_cnt_d;
   logic [vaddr_width_p-1:0]        dl_q [rpt_latency_p];
   logic [vaddr_width_p-1:0]        dl_d [rpt_latency_p];

   logic signed [vaddr_width_p-1:0] stride_sx;
   logic [vaddr_width_p-1:0]        base_tap, first_addr, next_addr;
   logic                            trigger, handshake;

   assign rpt_w_v_o      = ld_v_i & (state_q != e_init) & ~reset_i;
   assign rpt_pc_o       = ld_pc_i;
   assign rpt_eff_addr_o = ld_eff_addr_i;

   // The oldest delay-line tap lines up with the RPT's answer for that load
   assign base_tap   = dl_q[rpt_latency_p-1];
   assign stride_sx  = sext(stride_i);
   assign first_addr = base_tap + stride_sx;
   assign next_addr  = addr_q + stride_q;
   assign trigger    = stride_v_i & (armed_q | confirm_discovery_i) & (stride_i != '0);

   // Once offered, a request is held through demand traffic until accepted
   assign pf_v_o     = ~reset_i & (state_q == e_issue) & (hold_q | ~demand_v_i);
   assign handshake  = pf_v_o & pf_ready_i;
   assign pf_addr_o  = reset_i ? '0 : addr_q;
   assign busy_o     = ~reset_i & (state_q == e_issue);
   assign drop_cnt_o = drop_cnt_q;

   always_comb begin
      state_d     = state_q;
      armed_d     = confirm_discovery_i ? 1'b1 : (start_discovery_i ? 1'b0 : armed_q);
      hold_d      = pf_v_o & ~pf_ready_i;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      base_d      = base_q;
      stride_d    = stride_q;
      drop_cnt_d  = drop_cnt_q;
      dl_d[0]     = rpt_eff_addr_o;
      for (int i = 1; i < rpt_latency_p; i++) dl_d[i] = dl_q[i-1];

      case (state_q)
         e_init: if (rpt_init_done_i) state_d = e_idle;
         e_idle: begin
            if (trigger && same_page(first_addr, base_tap)) begin
               stride_d    = stride_sx;
               base_d      = base_tap;
               addr_d      = first_addr;
               remaining_d = 3'(degree_p);
               state_d     = e_issue;
            end
         end
         e_issue: begin
            if (trigger && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
            if (handshake) begin
               remaining_d = remaining_q - 3'd1;
               addr_d      = next_addr;
               if ((remaining_q == 3'd1) || !same_page(next_addr, base_q)) state_d = e_idle;
            end
         end
         default: state_d = e_init;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= e_init;
         armed_q     <= 1'b0;
         hold_q      <= 1'b0;
         remaining_q <= '0;
         addr_q      <= '0;
         base_q      <= '0;
         stride_q    <= '0;
         drop_cnt_q  <= '0;
         for (int i = 0; i < rpt_latency_p; i++) dl_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         hold_q      <= hold_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         base_q      <= base_d;
         stride_q    <= stride_d;
         drop_cnt_q  <= drop_cnt_d;
         for (int i = 0; i < rpt_latency_p; i++) dl_q[i] <= dl_d[i];
      end
   end

endmodule

// File: tb/tb_bp_be_stride_pf_ctrl.sv
// Directed bench for bp_be_stride_pf_ctrl; expected prefetch addresses go through a
// scoreboard queue that a negedge monitor drains on every accepted request.

module tb_bp_be_stride_pf_ctrl;

   localparam int V      = 39;
   localparam int SW     = 8;
   localparam int DEGREE = 2;
   localparam int LAT    = 2;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b1;
   logic          ld_v_i = 1'b0;
   logic [V-1:0]  ld_pc_i = '0;
   logic [V-1:0]  ld_eff_addr_i = '0;
   logic          rpt_w_v_o;
   logic [V-1:0]  rpt_pc_o;
   logic [V-1:0]  rpt_eff_addr_o;
   logic          rpt_init_done_i = 1'b0;
   logic          stride_v_i = 1'b0;
   logic [SW-1:0] stride_i = '0;
   logic          start_discovery_i = 1'b0;
   logic          confirm_discovery_i = 1'b0;
   logic          demand_v_i = 1'b0;
   logic          pf_v_o;
   logic [V-1:0]  pf_addr_o;
   logic          pf_ready_i = 1'b1;
   logic          busy_o;
   logic [7:0]    drop_cnt_o;

   int            n_assert = 0;
   int            n_fail = 0;
   logic [V-1:0]  exp_q [$];
   logic          armed_m = 1'b0;

   bp_be_stride_pf_ctrl #(.stride_width_p(SW), .degree_p(DEGREE), .rpt_latency_p(LAT)) dut
     (.clk_i(clk_i), .reset_i(reset_i), .ld_v_i(ld_v_i), .ld_pc_i(ld_pc_i),
      .ld_eff_addr_i(ld_eff_addr_i), .rpt_w_v_o(rpt_w_v_o), .rpt_pc_o(rpt_pc_o),
      .rpt_eff_addr_o(rpt_eff_addr_o), .rpt_init_done_i(rpt_init_done_i),
      .stride_v_i(stride_v_i), .stride_i(stride_i), .start_discovery_i(start_discovery_i),
      .confirm_discovery_i(confirm_discovery_i), .demand_v_i(demand_v_i), .pf_v_o(pf_v_o),
      .pf_addr_o(pf_addr_o), .pf_ready_i(pf_ready_i), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o));

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle;
      #3;
   endtask

   // Reference walk: same-page addresses base+k*stride, at most DEGREE of them
   task automatic push_expected(input logic [V-1:0] base, input logic [SW-1:0] s);
      logic [V-1:0] sx, a;
      int n;
      sx = {{(V-SW){s[SW-1]}}, s};
      a = base + sx;
      n = 0;
      while (n < DEGREE && a[V-1:12] == base[V-1:12]) begin
         exp_q.push_back(a);
         a = a + sx;
         n++;
      end
   endtask

   task automatic fire(input logic [V-1:0] base, input logic [SW-1:0] s, input logic c);
      ld_v_i = 1'b1;
      ld_eff_addr_i = base;
      ld_pc_i = base + 39'h400;
      tick;
      ld_v_i = 1'b0;
      repeat (LAT-1) tick;
      if ((armed_m || c) && s != '0) push_expected(base, s);
      if (c) armed_m = 1'b1;
      stride_v_i = 1'b1;
      stride_i = s;
      confirm_discovery_i = c;
      tick;
      stride_v_i = 1'b0;
      confirm_discovery_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy_o) && k < 50) begin
         tick;
         k++;
      end
      settle;
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_sb_left"}, exp_q.size(), 0);
      tick;
   endtask

   always @(negedge clk_i) begin
      if (pf_v_o && pf_ready_i) begin
         if (exp_q.size() == 0) check("pf_unexpected", pf_v_o, 0);
         else check("pf_addr_sb", pf_addr_o, exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset values
      tick;
      settle;
      check("rst_pf_v", pf_v_o, 0);
      check("rst_pf_addr", pf_addr_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_rpt_w_v", rpt_w_v_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      tick;
      reset_i = 1'b0;
      ld_v_i = 1'b1;
      ld_pc_i = 39'h12_3456;
      ld_eff_addr_i = 39'h7_8000;
      for (int i = 0; i < 32; i++) begin
         settle;
         check("init_rpt_w_v", rpt_w_v_o, 0);
         tick;
      end
      rpt_init_done_i = 1'b1;
      tick;
      settle;
      check("init_done_rpt_w_v", rpt_w_v_o, 1);
      check("rpt_pc", rpt_pc_o, 39'h12_3456);
      check("rpt_eff", rpt_eff_addr_o, 39'h7_8000);
      tick;
      ld_v_i = 1'b0;
      settle;
      check("ld_off_rpt_w_v", rpt_w_v_o, 0);
      tick;

      // Basic confirmed stride, one prefetch per cycle
      fire(39'h1000, 8'h40, 1'b1);
      settle;
      check("basic_v0", pf_v_o, 1);
      check("basic_a0", pf_addr_o, 39'h1040);
      tick;
      settle;
      check("basic_v1", pf_v_o, 1);
      check("basic_a1", pf_addr_o, 39'h1080);
      tick;
      settle;
      check("basic_done_v", pf_v_o, 0);
      check("basic_done_busy", busy_o, 0);
      tick;
      wait_idle("basic");

      // Backpressure and demand interaction
      pf_ready_i = 1'b0;
      fire(39'h1000, 8'h40, 1'b0);
      for (int i = 0; i < 3; i++) begin
         settle;
         check("bp_v", pf_v_o, 1);
         check("bp_a", pf_addr_o, 39'h1040);
         tick;
      end
      for (int i = 0; i < 4; i++) begin
         demand_v_i = (i % 2 == 0);
         settle;
         check("bp_dem_v", pf_v_o, 1);
         check("bp_dem_a", pf_addr_o, 39'h1040);
         tick;
      end
      demand_v_i = 1'b1;
      pf_ready_i = 1'b1;
      settle;
      check("bp_hs_v", pf_v_o, 1);
      tick;
      settle;
      check("bp_demand_blocks", pf_v_o, 0);
      tick;
      demand_v_i = 1'b0;
      settle;
      check("bp_second_v", pf_v_o, 1);
      check("bp_second_a", pf_addr_o, 39'h1080);
      tick;
      wait_idle("bp");

      // Page crossing on the first and on a later address
      fire(39'h1FC0, 8'h40, 1'b0);
      settle;
      check("page_first_busy", busy_o, 0);
      check("page_first_v", pf_v_o, 0);
      tick;
      wait_idle("page_first");
      fire(39'h1F80, 8'h40, 1'b0);
      settle;
      check("page_one_a", pf_addr_o, 39'h1FC0);
      tick;
      settle;
      check("page_one_end", busy_o, 0);
      tick;
      wait_idle("page_one");

      // Negative stride walks downward
      fire(39'h2010, 8'hF8, 1'b0);
      settle;
      check("neg_a0", pf_addr_o, 39'h2008);
      tick;
      settle;
      check("neg_a1", pf_addr_o, 39'h2000);
      tick;
      wait_idle("neg");

      // Disarmed by start_discovery, then re-armed with start and confirm together
      start_discovery_i = 1'b1;
      armed_m = 1'b0;
      tick;
      start_discovery_i = 1'b0;
      fire(39'h3000, 8'h40, 1'b0);
      for (int i = 0; i < 3; i++) begin
         settle;
         check("unarmed_v", pf_v_o, 0);
         check("unarmed_busy", busy_o, 0);
         tick;
      end
      start_discovery_i = 1'b1;
      confirm_discovery_i = 1'b1;
      armed_m = 1'b1;
      tick;
      start_discovery_i = 1'b0;
      confirm_discovery_i = 1'b0;
      fire(39'h3000, 8'h40, 1'b0);
      wait_idle("confirm_wins");
      fire(39'h3000, 8'h00, 1'b0);
      settle;
      check("zero_stride_busy", busy_o, 0);
      tick;
      wait_idle("zero_stride");

      // Triggers dropped while stalled, then reset mid-sequence
      settle;
      check("drop_start", drop_cnt_o, 0);
      tick;
      pf_ready_i = 1'b0;
      fire(39'h4000, 8'h40, 1'b0);
      stride_v_i = 1'b1;
      stride_i = 8'h40;
      repeat (10) tick;
      settle;
      check("drop_10", drop_cnt_o, 10);
      tick;
      repeat (289) tick;
      stride_v_i = 1'b0;
      settle;
      check("drop_sat", drop_cnt_o, 255);
      check("drop_inflight_a", pf_addr_o, 39'h4040);
      check("drop_inflight_v", pf_v_o, 1);
      tick;
      reset_i = 1'b1;
      rpt_init_done_i = 1'b0;
      ld_v_i = 1'b1;
      exp_q.delete();
      settle;
      check("mid_rst_pf_v", pf_v_o, 0);
      check("mid_rst_pf_addr", pf_addr_o, 0);
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_rpt_w_v", rpt_w_v_o, 0);
      tick;
      reset_i = 1'b0;
      armed_m = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle;
         check("post_rst_pf_v", pf_v_o, 0);
         check("post_rst_busy", busy_o, 0);
         check("post_rst_rpt_w_v", rpt_w_v_o, 0);
         check("post_rst_drop", drop_cnt_o, 0);
         tick;
      end
      rpt_init_done_i = 1'b1;
      pf_ready_i = 1'b1;
      tick;
      settle;
      check("reinit_rpt_w_v", rpt_w_v_o, 1);
      tick;
      ld_v_i = 1'b0;
      fire(39'h5000, 8'h40, 1'b1);
      settle;
      check("recover_a0", pf_addr_o, 39'h5040);
      tick;
      wait_idle("recover");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
